buf_bus_arbiter: RTL and testbench

- Round-robin arbiter sharing one registered 1-bit buffer output (Y) between N requesters.
- Each requester presents a request and a 1-bit data line. The granted requester's data passes through the shared buffer to Y with one cycle of latency.
- Sits between the requester logic and the single shared buffered line. It is the only block that decides which requester drives that line.

---
 rtl/buf_bus_arbiter.sv | 109 ++++++++++
 tb/tb_buf_bus_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/buf_bus_arbiter.sv
// Round-robin arbiter that lends one registered 1-bit buffer (Y) to one of N requesters.
// The owner's data bit reaches Y one cycle after it is sampled; a hold limit bounds starvation.
module buf_bus_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] A,
    output logic [N-1:0] grant,
    output logic         Y,
    output logic         Y_valid
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_HOLD - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    // Returns {found, index} of the first set bit of vec, scanning start, start+1, ... with wrap.
    function automatic logic [IW:0] rr_pick(input logic [N-1:0] vec, input logic [IW-1:0] start);
        logic [IW:0] result;
        int          idx;
        result = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= N) idx = idx - N;
            if (vec[idx]) result = {1'b1, IW'(idx)};
        end
        return result;
    endfunction

    logic [0:0]    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [CW-1:0] cnt;

    logic [N-1:0]  others;
    logic [IW-1:0] next_ptr;
    logic          at_limit;
    logic          release_now;
    logic [IW:0]   pick_idle;
    logic [IW:0]   pick_next;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        others      = req & ~grant;
        next_ptr    = (owner == LAST_IDX) ? '0 : owner + 1'b1;
        at_limit    = (cnt == CNT_MAX);
        release_now = 1'b0;
        if (state == S_GRANT)
            release_now = !req[owner] || (at_limit && (|others));
        pick_idle   = rr_pick(req, ptr);
        pick_next   = rr_pick(others, next_ptr);
    end

    // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ptr     <= '0;
            owner   <= '0;
            cnt     <= '0;
            grant   <= '0;
            Y       <= 1'b0;
            Y_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    Y       <= 1'b0;
                    Y_valid <= 1'b0;
                    if (pick_idle[IW]) begin
                        state <= S_GRANT;
                        owner <= pick_idle[IW-1:0];
                        grant <= {{(N-1){1'b0}}, 1'b1} << pick_idle[IW-1:0];
                        cnt   <= '0;
                    end
                end
                S_GRANT: begin
                    // The outgoing owner's last sampled bit is still delivered on the release edge.
                    Y       <= A[owner];
                    Y_valid <= 1'b1;
                    if (release_now) begin
                        ptr <= next_ptr;
                        cnt <= '0;
                        if (pick_next[IW]) begin
                            owner <= pick_next[IW-1:0];
                            grant <= {{(N-1){1'b0}}, 1'b1} << pick_next[IW-1:0];
                        end else begin
                            state <= S_IDLE;
                            grant <= '0;
                        end
                    end else if (!at_limit) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buf_bus_arbiter.sv
// Self-checking bench for buf_bus_arbiter: directed scenarios plus random traffic,
// all compared against a cycle-level reference model of the arbitration rules.
module tb_buf_bus_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] a;
    logic [N-1:0] grant;
    logic         y;
    logic         y_valid;

    int tests;
    int fails;

    // Reference model: owner index (-1 when idle), pointer, cycles held so far.
    int           m_owner;
    int           m_ptr;
    int           m_held;
    logic [N-1:0] m_grant;
    logic         m_y;
    logic         m_yv;

    buf_bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .A       (a),
        .grant   (grant),
        .Y       (y),
        .Y_valid (y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] vec, input int start);
        for (int k = 0; k < N; k++) begin
            if (vec[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_grant = '0;
        m_y     = 1'b0;
        m_yv    = 1'b0;
    endtask

    task automatic model_edge();
        logic [N-1:0] oth;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_owner >= 0) begin
            m_y  = a[m_owner];
            m_yv = 1'b1;
        end else begin
            m_y  = 1'b0;
            m_yv = 1'b0;
        end
        if (m_owner < 0) begin
            m_owner = pick(req, m_ptr);
            m_held  = 0;
        end else begin
            m_held++;
            oth = req;
            oth[m_owner] = 1'b0;
            if (!req[m_owner] || (m_held >= MAX_HOLD && oth != '0)) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = pick(oth, m_ptr);
                m_held  = 0;
            end
        end
        m_grant = '0;
        if (m_owner >= 0) m_grant[m_owner] = 1'b1;
    endtask

    // One clock: model advances on the edge, outputs are compared 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".grant"}, grant, m_grant);
        check({tag, ".Y"}, N'(y), N'(m_y));
        check({tag, ".Y_valid"}, N'(y_valid), N'(m_yv));
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        logic [3:0] bits;
        tests = 0;
        fails = 0;
        model_reset();

        // Reset held with everything requesting.
        rst_n = 1'b0;
        req   = 4'b1111;
        a     = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        check("reset.grant", grant, 4'b0000);
        check("reset.Y", N'(y), 4'b0000);
        check("reset.Y_valid", N'(y_valid), 4'b0000);

        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0100;
        a     = 4'b0100;
        step("post_reset");
        check("post_reset.onehot", grant, 4'b0100);
        step("post_reset_data");
        check("post_reset.Y_valid_now", N'(y_valid), 4'b0001);

        // Buffer data path through requester 0.
        req  = 4'b0001;
        bits = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            a = {3'b000, bits[3 - i]};
            step("datapath");
        end
        a = 4'b0000;
        steps("datapath_tail", 2);

        req = 4'b0000;
        steps("to_idle", 3);

        // Full round-robin with every requester asserted.
        req = 4'b1111;
        for (int i = 0; i < 42; i++) begin
            a = 4'($urandom);
            step("round_robin");
        end

        // Early release of owner 1 while requester 3 waits.
        req = 4'b0000;
        steps("idle2", 2);
        req = 4'b0010;
        step("early.grant1");
        check("early.owner1", grant, 4'b0010);
        req = 4'b1010;
        steps("early.hold", 2);
        req = 4'b1000;
        step("early.release");
        check("early.owner3", grant, 4'b1000);

        // Lone holder keeps the grant past the hold limit.
        req = 4'b0000;
        steps("idle3", 2);
        req = 4'b0100;
        for (int i = 0; i < 40; i++) begin
            a = 4'($urandom);
            step("lone");
        end
        check("lone.still_owner", grant, 4'b0100);

        // Asynchronous reset between clock edges while requester 1 owns the line.
        req = 4'b0000;
        steps("idle4", 2);
        req = 4'b0010;
        a   = 4'b0010;
        steps("pre_async", 2);
        check("pre_async.owner1", grant, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("async.grant", grant, 4'b0000);
        check("async.Y", N'(y), 4'b0000);
        check("async.Y_valid", N'(y_valid), 4'b0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        step("restart");
        check("restart.from_ptr0", grant, 4'b0001);

        // Random traffic, biased toward dense requests, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            req   = 4'($urandom) | 4'($urandom);
            a     = 4'($urandom);
            rst_n = ($urandom_range(0, 99) != 0);
            step("random");
        end
        rst_n = 1'b1;
        req   = 4'b0000;
        steps("drain", 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
